transaction_sequencer: RTL and testbench

Parametrised step sequencer for the coin transaction flow. It replaces the fixed 3-bit step/`done_process` mux arrangement with a generic controller. It issues `NUM_STEPS` ordered steps to the datapath, hash and memory units, and waits for each unit's per-step done. It adds auto-completing steps, a per-step timeout with bounded retry, abort, and error reporting back to `main_control`.

---
 rtl/transaction_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_transaction_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transaction_sequencer.sv
// ---------------------------------------------------------------------------
// transaction_sequencer
//
// Generic step sequencer for the coin transaction flow. Issues NUM_STEPS
// ordered steps to the datapath, hash and memory units. Each issue produces
// a one-cycle step_start pulse and waits for that step's done bit. Steps
// flagged in AUTO_MASK complete without a done. A step that waits too long
// is re-issued up to MAX_RETRIES times before the transaction fails. An
// abort cancels the transaction with a distinct error code.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin a transaction (sampled only when idle)
//   abort        in   cancel the running transaction (ISSUE/WAIT only)
//   done_step    in   bit i = unit completion for step i+1
//   step         out  current step 1..NUM_STEPS, 0 when idle
//   step_start   out  one-cycle pulse per issue / re-issue
//   busy         out  high in every state except IDLE
//   finished     out  one-cycle pulse when the last step completes
//   error        out  one-cycle pulse on failure
//   error_code   out  01 timeout exhausted, 10 abort; held until next start
//   error_step   out  step that failed; held until next start
//   retry_count  out  retries used on the current step
//   state_dbg    out  raw FSM state for observation
//
// Unit handshake: step_start is the request for the step shown on step.
// The owning unit answers with its done_step bit at any later cycle while
// the sequencer is in WAIT; a done seen during ISSUE (the request cycle
// itself) or for any other step is not an answer and is dropped. Only one
// request is outstanding at a time.
//
// Every output is a flop or a decode of the state flop only, so nothing
// on an input reaches an output within the same cycle.
// ---------------------------------------------------------------------------
module transaction_sequencer #(
    parameter int NUM_STEPS      = 4,
    parameter int STEP_W         = 3,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 2,
    parameter logic [NUM_STEPS-1:0] AUTO_MASK = NUM_STEPS'(4'b0100),
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_STEPS-1:0] done_step,
    output logic [STEP_W-1:0]    step,
    output logic                 step_start,
    output logic                 busy,
    output logic                 finished,
    output logic                 error,
    output logic [1:0]           error_code,
    output logic [STEP_W-1:0]    error_step,
    output logic [RC_W-1:0]      retry_count,
    output logic [2:0]           state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    localparam logic [1:0] EC_TIMEOUT = 2'b01;
    localparam logic [1:0] EC_ABORT   = 2'b10;

    // Timer only has to reach TIMEOUT_CYCLES-1.
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [TW-1:0]     TMAX_V = TW'(TMAX);
    localparam logic [RC_W-1:0]   RMAX_V = RC_W'(MAX_RETRIES);
    localparam logic [STEP_W-1:0] LAST_V = STEP_W'(NUM_STEPS);
    localparam logic [STEP_W-1:0] ONE_V  = STEP_W'(1);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic          cur_done;
    logic          timeout_hit;
    logic          last_step;

    // Completion of the step currently shown on `step`. A loop compare
    // avoids indexing done_step with a wider-than-needed step value.
    always_comb begin
        cur_done = 1'b0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (step == STEP_W'(i + 1)) begin
                cur_done = done_step[i] | AUTO_MASK[i];
            end
        end
    end

    // With TIMEOUT_CYCLES = 0 the timer still runs but never fires.
    assign timeout_hit = TO_EN && (timer == TMAX_V);
    assign last_step   = (step == LAST_V);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            step        <= '0;
            timer       <= '0;
            retry_count <= '0;
            error_code  <= 2'b00;
            error_step  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    step <= '0;
                    if (start) begin
                        step        <= ONE_V;
                        retry_count <= '0;
                        error_code  <= 2'b00;
                        error_step  <= '0;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    timer <= '0;
                    if (abort) begin
                        error_code <= EC_ABORT;
                        state      <= S_FAIL;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // abort > completion > timeout
                    if (abort) begin
                        error_code <= EC_ABORT;
                        state      <= S_FAIL;
                    end else if (cur_done) begin
                        if (last_step) begin
                            state <= S_DONE;
                        end else begin
                            step        <= step + ONE_V;
                            retry_count <= '0;
                            state       <= S_ISSUE;
                        end
                    end else if (timeout_hit) begin
                        if (retry_count < RMAX_V) begin
                            retry_count <= retry_count + RC_W'(1);
                            state       <= S_ISSUE;
                        end else begin
                            error_code <= EC_TIMEOUT;
                            state      <= S_FAIL;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_DONE: begin
                    step  <= '0;
                    state <= S_IDLE;
                end

                S_FAIL: begin
                    error_step <= step;
                    step       <= '0;
                    state      <= S_IDLE;
                end

                default: begin
                    step  <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign step_start = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign finished   = (state == S_DONE);
    assign error      = (state == S_FAIL);
    assign state_dbg  = state;

endmodule

// File: tb/tb_transaction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_transaction_sequencer
//
// Directed bench for transaction_sequencer. Three instances: the default
// four-step configuration, a single auto step with no timeout, and a single
// external step with no timeout. Inputs change 1 ns after the rising edge,
// outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_transaction_sequencer;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- main DUT (defaults) ----------------
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] done_step = 4'b0000;
    logic [2:0] step;
    logic       step_start, busy, finished, error;
    logic [1:0] error_code;
    logic [2:0] error_step;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    transaction_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .done_step   (done_step),
        .step        (step),
        .step_start  (step_start),
        .busy        (busy),
        .finished    (finished),
        .error       (error),
        .error_code  (error_code),
        .error_step  (error_step),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- single auto step, no timeout ----------------
    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic [0:0] done_b = 1'b0;
    logic [0:0] step_b;
    logic       step_start_b, busy_b, finished_b, error_b;
    logic [1:0] error_code_b;
    logic [0:0] error_step_b;
    logic [1:0] retry_count_b;
    logic [2:0] state_dbg_b;

    transaction_sequencer #(
        .NUM_STEPS(1), .STEP_W(1), .TIMEOUT_CYCLES(0), .MAX_RETRIES(2), .AUTO_MASK(1'b1)
    ) dut_b (
        .clock       (clock),
        .reset       (reset),
        .start       (start_b),
        .abort       (abort_b),
        .done_step   (done_b),
        .step        (step_b),
        .step_start  (step_start_b),
        .busy        (busy_b),
        .finished    (finished_b),
        .error       (error_b),
        .error_code  (error_code_b),
        .error_step  (error_step_b),
        .retry_count (retry_count_b),
        .state_dbg   (state_dbg_b)
    );

    // ---------------- single external step, no timeout ----------------
    logic       start_c = 1'b0;
    logic       abort_c = 1'b0;
    logic [0:0] done_c = 1'b0;
    logic [0:0] step_c;
    logic       step_start_c, busy_c, finished_c, error_c;
    logic [1:0] error_code_c;
    logic [0:0] error_step_c;
    logic [1:0] retry_count_c;
    logic [2:0] state_dbg_c;

    transaction_sequencer #(
        .NUM_STEPS(1), .STEP_W(1), .TIMEOUT_CYCLES(0), .MAX_RETRIES(2), .AUTO_MASK(1'b0)
    ) dut_c (
        .clock       (clock),
        .reset       (reset),
        .start       (start_c),
        .abort       (abort_c),
        .done_step   (done_c),
        .step        (step_c),
        .step_start  (step_start_c),
        .busy        (busy_c),
        .finished    (finished_c),
        .error       (error_c),
        .error_code  (error_code_c),
        .error_step  (error_step_c),
        .retry_count (retry_count_c),
        .state_dbg   (state_dbg_c)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fin_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_c_cnt = 0;
    int prev_step = 0;
    int step_log[$];
    int ss_cyc[$];
    int ss_step[$];
    int ss_retry[$];
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // One clock: advance to 1 ns past the edge and log observed events.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (step_start) begin
            ss_cyc.push_back(cyc);
            ss_step.push_back(int'(step));
            ss_retry.push_back(int'(retry_count));
        end
        if (int'(step) != prev_step) begin
            step_log.push_back(int'(step));
            prev_step = int'(step);
        end
        if (finished) fin_cnt++;
        if (error) err_cnt++;
        if (finished && error) both_cnt++;
        if (error_c) err_c_cnt++;
    endtask

    task automatic clear_logs();
        fin_cnt = 0;
        err_cnt = 0;
        step_log.delete();
        ss_cyc.delete();
        ss_step.delete();
        ss_retry.delete();
    endtask

    // start, complete step 1 immediately, return observing ISSUE of step 2
    task automatic go_to_step2();
        start = 1'b1; tick(); start = 1'b0;   // ISSUE step 1
        tick();                               // WAIT step 1
        done_step = 4'b0001; tick(); done_step = 4'b0000;  // ISSUE step 2
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        // reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_step", step, 0);
        check("rst_step_start", step_start, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_error", error, 0);
        check("rst_error_code", error_code, 0);
        check("rst_error_step", error_step, 0);
        check("rst_retry", retry_count, 0);
        check("rst_state", state_dbg, 0);

        // ---- test 1: nominal flow, step 3 auto ----
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;   // t+1 ISSUE step 1
        check("t1_issue1_step", step, 1);
        check("t1_issue1_pulse", step_start, 1);
        check("t1_issue1_busy", busy, 1);
        tick(); tick(); tick();               // WAIT cycles t+2..t+4
        done_step = 4'b0001; tick(); done_step = 4'b0000;
        check("t1_issue2_step", step, 2);
        tick();                               // WAIT 1 of step 2
        done_step = 4'b0010; tick(); done_step = 4'b0000;
        check("t1_issue3_step", step, 3);
        tick();                               // WAIT step 3 (auto)
        tick();                               // ISSUE step 4
        check("t1_issue4_step", step, 4);
        check("t1_issue4_pulse", step_start, 1);
        tick();                               // WAIT 1 of step 4
        done_step = 4'b1000; tick(); done_step = 4'b0000;
        check("t1_done_finished", finished, 1);
        check("t1_done_busy", busy, 1);
        check("t1_done_code", error_code, 0);
        tick();
        check("t1_idle_step", step, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_starts", ss_cyc.size(), 4);
        check("t1_fin_cnt", fin_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        check("t1_seq_len", step_log.size(), exp_q.size());
        foreach (exp_q[i]) check($sformatf("t1_seq_%0d", i), at(step_log, i), int'(exp_q[i]));

        // ---- test 2: step 2 never completes ----
        clear_logs();
        go_to_step2();
        for (int i = 0; i < 80 && !error; i++) tick();
        check("t2_error_seen", error, 1);
        check("t2_code", error_code, 1);
        check("t2_finished", finished, 0);
        check("t2_starts", ss_cyc.size(), 4);
        check("t2_step_a", at(ss_step, 1), 2);
        check("t2_step_b", at(ss_step, 2), 2);
        check("t2_step_c", at(ss_step, 3), 2);
        check("t2_gap_1", at(ss_cyc, 2) - at(ss_cyc, 1), 17);
        check("t2_gap_2", at(ss_cyc, 3) - at(ss_cyc, 2), 17);
        check("t2_fail_gap", cyc - at(ss_cyc, 3), 17);
        check("t2_retry_0", at(ss_retry, 1), 0);
        check("t2_retry_1", at(ss_retry, 2), 1);
        check("t2_retry_2", at(ss_retry, 3), 2);
        tick();
        check("t2_idle_busy", busy, 0);
        check("t2_idle_error", error, 0);
        check("t2_err_step", error_step, 2);
        check("t2_code_held", error_code, 1);

        // ---- test 3: done in 16th WAIT cycle, stray done bits ignored ----
        clear_logs();
        go_to_step2();
        check("t3_code_cleared", error_code, 0);
        check("t3_step_cleared", error_step, 0);
        for (int i = 0; i < 16; i++) begin
            done_step = (i == 4) ? 4'b1001 : 4'b0000;
            tick();
        end
        done_step = 4'b0000;
        check("t3_w16_step", step, 2);
        check("t3_w16_pulse", step_start, 0);
        check("t3_w16_retry", retry_count, 0);
        done_step = 4'b0010; tick(); done_step = 4'b0000;
        check("t3_adv_step", step, 3);
        check("t3_adv_retry", retry_count, 0);
        check("t3_adv_pulse", step_start, 1);
        tick();                               // WAIT step 3 (auto)
        done_step = 4'b1000; tick();          // ISSUE step 4, done ignored
        done_step = 4'b0000;
        check("t3_issue4_step", step, 4);
        tick();                               // WAIT step 4
        check("t3_wait4_state", state_dbg, 2);
        check("t3_wait4_fin", finished, 0);
        done_step = 4'b1000; tick(); done_step = 4'b0000;
        check("t3_finished", finished, 1);
        tick();

        // ---- test 4: abort with done in WAIT of step 1 ----
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;   // ISSUE step 1
        tick();                               // WAIT step 1
        abort = 1'b1; done_step = 4'b0001; tick();
        abort = 1'b0; done_step = 4'b0000;
        check("t4_error", error, 1);
        check("t4_code", error_code, 2);
        check("t4_step", step, 1);
        check("t4_finished", finished, 0);
        tick();
        check("t4_err_step", error_step, 1);
        check("t4_busy", busy, 0);
        check("t4_starts", ss_cyc.size(), 1);

        // ---- test 5: restart ignored while busy, reset mid WAIT ----
        clear_logs();
        start = 1'b1; tick();                 // ISSUE step 1, start held
        tick();                               // WAIT step 1
        done_step = 4'b0001; tick(); done_step = 4'b0000;
        check("t5_restart_ignored", step, 2);
        start = 1'b0;
        tick();                               // WAIT step 2
        done_step = 4'b0010; tick(); done_step = 4'b0000;  // ISSUE 3
        tick(); tick(); tick();               // WAIT 3, ISSUE 4, WAIT 4
        check("t5_wait4_step", step, 4);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5_rst_step", step, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_code", error_code, 0);
        check("t5_rst_err_step", error_step, 0);
        check("t5_rst_retry", retry_count, 0);
        tick();
        check("t5_fin_cnt", fin_cnt, 0);
        check("t5_err_cnt", err_cnt, 0);

        // ---- test 6: single-step instances ----
        start_b = 1'b1; start_c = 1'b1; tick();
        start_b = 1'b0; start_c = 1'b0;
        check("t6_b_issue", step_start_b, 1);
        tick();
        check("t6_b_wait_fin", finished_b, 0);
        tick();
        check("t6_b_finished", finished_b, 1);
        tick();
        check("t6_b_idle", busy_b, 0);
        for (int i = 0; i < 40; i++) tick();
        check("t6_c_busy", busy_c, 1);
        check("t6_c_state", state_dbg_c, 2);
        check("t6_c_no_error", err_c_cnt, 0);
        check("t6_c_no_retry", retry_count_c, 0);

        check("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
